// File: rtl/mips_pkg.sv
// Shared MIPS definitions: R-type funct codes for HI/LO ops and the
// multiply/divide sequencer state type.
package mips_pkg;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } muldiv_state_t;

endpackage

// File: rtl/mips_muldiv_datapath.sv
// Shift-add multiply / restoring divide datapath with sign fix-up
// and the registered {HI,LO} result.
module mips_muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               commit,
  input  logic               is_div,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] result,
  output logic               div_zero
);

  localparam int W = WIDTH;

  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_step;
  logic [2*W-1:0] fixed;
  logic [W-1:0]   opr;
  logic [W-1:0]   orig_a;
  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;
  logic [W:0]     add_sum;
  logic [W:0]     part;
  logic [W:0]     trial;
  logic           neg_a;
  logic           neg_b;
  logic           zero_b;
  logic           sa;
  logic           sb;

  assign sa    = is_signed & op_a[W-1];
  assign sb    = is_signed & op_b[W-1];
  assign mag_a = sa ? -op_a : op_a;
  assign mag_b = sb ? -op_b : op_b;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign add_sum = {1'b0, acc[2*W-1:W]}
                 + (acc[0] ? {1'b0, opr} : {(W+1){1'b0}});
  assign part    = acc[2*W-1:W-1];
  assign trial   = part - {1'b0, opr};

  always_comb begin
    acc_step = {add_sum, acc[W-1:1]};
    if (is_div) begin
      if (trial[W])
        acc_step = {part[W-1:0], acc[W-2:0], 1'b0};
      else
        acc_step = {trial[W-1:0], acc[W-2:0], 1'b1};
    end
  end

  assign quo = acc[W-1:0];
  assign rem = acc[2*W-1:W];

  always_comb begin
    fixed = acc;
    if (is_div) begin
      if (zero_b)
        fixed = {orig_a, {W{1'b1}}};
      else
        fixed = {(neg_a ? -rem : rem),
                 ((neg_a ^ neg_b) ? -quo : quo)};
    end else if (neg_a ^ neg_b) begin
      fixed = -acc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      opr      <= '0;
      orig_a   <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      zero_b   <= 1'b0;
      result   <= '0;
      div_zero <= 1'b0;
    end else begin
      if (load) begin
        acc    <= {{W{1'b0}}, (is_div ? mag_a : mag_b)};
        opr    <= is_div ? mag_b : mag_a;
        orig_a <= op_a;
        neg_a  <= sa;
        neg_b  <= sb;
        zero_b <= (op_b == '0);
      end else if (step) begin
        acc <= acc_step;
      end
      if (commit) begin
        result   <= fixed;
        div_zero <= is_div & zero_b;
      end
    end
  end

endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine: sequencer FSM and bit counter
// around the shared multiply/divide datapath.
module mips_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [5:0]         funct,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t state;
  muldiv_state_t state_next;

  logic [CW-1:0] count;
  logic [5:0]    funct_q;
  logic [5:0]    funct_sel;
  logic          valid;
  logic          accept;
  logic          last;
  logic          is_div;
  logic          is_signed;
  logic          dz;

  assign valid = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU)
              || (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  assign accept = (state == IDLE) && start && valid;
  assign last   = (count == CW'(WIDTH - 1));

  // decode the live funct while loading, the latched one afterwards
  assign funct_sel = accept ? funct : funct_q;
  assign is_div    = (funct_sel == FUNCT_DIV)
                  || (funct_sel == FUNCT_DIVU);
  assign is_signed = (funct_sel == FUNCT_MULT)
                  || (funct_sel == FUNCT_DIV);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = RUN;
      RUN:  if (last) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      funct_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        count   <= '0;
        funct_q <= funct;
      end else if (state == RUN) begin
        count <= count + 1'b1;
      end
    end
  end

  assign busy        = (state == RUN) || (state == FIX);
  assign done        = (state == DONE);
  assign div_by_zero = done & dz;

  mips_muldiv_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .step     (state == RUN),
    .commit   (state == FIX),
    .is_div   (is_div),
    .is_signed(is_signed),
    .op_a     (op_a),
    .op_b     (op_b),
    .result   (result),
    .div_zero (dz)
  );

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Self-checking bench for mips_muldiv_unit: directed corner cases and
// random operations against an arithmetic reference model.
module tb_mips_muldiv_unit;
  import mips_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [63:0] result;

  int total;
  int bad;

  mips_muldiv_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .funct      (funct),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .result     (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [5:0] f,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    if (f == FUNCT_MULT) begin
      p = sa * sb;
    end else if (f == FUNCT_MULTU) begin
      p = ua * ub;
    end else if (b == 32'd0) begin
      p = {a, 32'hFFFF_FFFF};
    end else if (f == FUNCT_DIV) begin
      q = sa / sb;
      r = sa % sb;
      p = {r[31:0], q[31:0]};
    end else begin
      uq = ua / ub;
      ur = ua % ub;
      p = {ur[31:0], uq[31:0]};
    end
    return p;
  endfunction

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || done) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  // issue one op; lat is the cycle (relative to start cycle) done was seen
  task automatic run_op(input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, output int lat,
                        output int bcnt, output logic [63:0] res,
                        output logic dz);
    wait_idle();
    @(negedge clk);
    start = 1'b1; funct = f; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    lat = 1; bcnt = 0;
    while (!done && lat < 60) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    dz  = div_by_zero;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, div_by_zero} !== 3'b000 || result !== 64'd0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b dbz=%b result=%h want 0",
               busy, done, div_by_zero, result);
    end
    reset = 1'b0;
  endtask

  task automatic test_multu_max();
    int lat, bc; logic [63:0] r; logic dz;
    run_op(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, r, dz);
    total++;
    if (lat !== 34) begin
      bad++; $display("FAIL multu_latency: got %0d want 34", lat);
    end
    total++;
    if (bc !== 33) begin
      bad++; $display("FAIL multu_busy: got %0d want 33", bc);
    end
    total++;
    if (r !== 64'hFFFF_FFFE_0000_0001) begin
      bad++; $display("FAIL multu_max: got %h want fffffffe00000001", r);
    end
  endtask

  task automatic test_mult_signed();
    int lat, bc; logic [63:0] r; logic dz;
    run_op(FUNCT_MULT, 32'hFFFF_FFFD, 32'd5, lat, bc, r, dz);
    total++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      bad++; $display("FAIL mult_neg3x5: got %h want fffffffffffffff1", r);
    end
    run_op(FUNCT_MULT, 32'h8000_0000, 32'h8000_0000, lat, bc, r, dz);
    total++;
    if (r !== 64'h4000_0000_0000_0000) begin
      bad++; $display("FAIL mult_minxmin: got %h want 4000000000000000", r);
    end
  endtask

  task automatic test_div();
    int lat, bc; logic [63:0] r; logic dz;
    run_op(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, lat, bc, r, dz);
    total++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      bad++; $display("FAIL div_neg7by2: got %h want fffffffffffffffd", r);
    end
    run_op(FUNCT_DIVU, 32'd100, 32'd7, lat, bc, r, dz);
    total++;
    if (r !== {32'd2, 32'd14} || dz !== 1'b0) begin
      bad++; $display("FAIL divu_100by7: got %h dbz=%b want %h dbz=0",
                      r, dz, {32'd2, 32'd14});
    end
    run_op(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, r, dz);
    total++;
    if (r !== 64'h0000_0000_8000_0000) begin
      bad++; $display("FAIL div_overflow: got %h want 0000000080000000", r);
    end
  endtask

  task automatic test_div_zero();
    int lat, bc; logic [63:0] r; logic dz;
    run_op(FUNCT_DIVU, 32'd100, 32'd0, lat, bc, r, dz);
    total++;
    if (lat !== 34) begin
      bad++; $display("FAIL dbz_latency: got %0d want 34", lat);
    end
    total++;
    if (dz !== 1'b1 || r !== {32'd100, 32'hFFFF_FFFF}) begin
      bad++; $display("FAIL dbz_result: got %h dbz=%b want %h dbz=1",
                      r, dz, {32'd100, 32'hFFFF_FFFF});
    end
    @(posedge clk); #1;
    total++;
    if (div_by_zero !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL dbz_pulse: dbz=%b done=%b want 0 0",
                      div_by_zero, done);
    end
  endtask

  task automatic test_handshake();
    int dones, done_at, seen;
    logic [63:0] r;
    wait_idle();
    @(negedge clk);
    start = 1'b1; funct = FUNCT_MULTU; op_a = 32'd3; op_b = 32'd4;
    @(posedge clk); #1;
    dones = 0; done_at = 0; r = '0;
    for (int n = 1; n <= 45; n++) begin
      start = (n == 5 || n == 20);
      op_a = 32'd9 + n; op_b = 32'd11;
      if (done) begin
        dones++; done_at = n; r = result;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    total++;
    if (dones !== 1 || done_at !== 34 || r !== 64'd12) begin
      bad++; $display("FAIL busy_start: dones=%0d at=%0d res=%h want 1 34 12",
                      dones, done_at, r);
    end
    @(negedge clk);
    start = 1'b1; funct = 6'h10; op_a = 32'd5; op_b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (busy || done) seen++;
      @(posedge clk); #1;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL bad_funct: active cycles=%0d want 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, seen; logic [63:0] r; logic dz;
    wait_idle();
    @(negedge clk);
    start = 1'b1; funct = FUNCT_DIV; op_a = $urandom; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || result !== 64'd0) begin
      bad++; $display("FAIL reset_mid: busy=%b result=%h want 0 0",
                      busy, result);
    end
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL reset_abort: done cycles=%0d want 0", seen);
    end
    run_op(FUNCT_MULTU, 32'd6, 32'd7, lat, bc, r, dz);
    total++;
    if (r !== 64'd42) begin
      bad++; $display("FAIL after_reset: got %h want 42", r);
    end
  endtask

  task automatic test_random();
    int lat, bc; logic [63:0] r, exp; logic dz, exp_dz;
    logic [5:0] f; logic [31:0] a, b;
    for (int i = 0; i < 32; i++) begin
      f = FUNCT_MULT + 6'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      exp    = model(f, a, b);
      exp_dz = (f == FUNCT_DIV || f == FUNCT_DIVU) && (b == 32'd0);
      run_op(f, a, b, lat, bc, r, dz);
      total++;
      if (r !== exp || dz !== exp_dz || lat !== 34) begin
        bad++;
        $display("FAIL random f=%h a=%h b=%h: got %h dbz=%b lat=%0d want %h dbz=%b lat=34",
                 f, a, b, r, dz, lat, exp, exp_dz);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0; funct = '0; op_a = '0; op_b = '0;
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_div();
    test_div_zero();
    test_handshake();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide engine for the MIPS CPU.
- Executes MULT, MULTU, DIV and DIVU on two 32-bit register operands.
- Produces a 64-bit {HI,LO} result plus a one-cycle completion pulse.
- The HI/LO register control stage consumes the result and commits it to HI/LO.

Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- funct  input  6  R-type function code: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU.
- op_a  input  WIDTH  rs value: multiplicand or dividend.
- op_b  input  WIDTH  rt value: multiplier or divisor.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when the result is valid.
- div_by_zero  output  1  pulses with done when a DIV/DIVU had op_b == 0.
- result  output  2*WIDTH  {HI,LO}.
  - Multiply: the full product.
  - Divide: {remainder, quotient}.
  - Held stable until the next completion.

Behaviour:
- Reset (synchronous, any state):
  - State goes to IDLE.
  - busy=0, done=0, div_by_zero=0, result=0.
  - The counter and internal accumulators are cleared.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- States: IDLE -> RUN -> FIX -> DONE -> IDLE.
- IDLE:
  - If start=1 and funct is one of the four codes, latch funct, the operand magnitudes and the sign flags, clear the counter, and go to RUN.
  - For signed ops the magnitudes are two's-complement absolute values; for unsigned ops the operands pass through unchanged.
  - start with any other funct is ignored; the unit stays in IDLE.
- RUN: exactly WIDTH cycles, one bit per cycle, counter 0..WIDTH-1. Go to FIX when counter == WIDTH-1.
  - Multiply: shift-add over a 2*WIDTH accumulator, LSB-first on the multiplier.
  - Divide: restoring division, MSB-first. If the trial subtraction is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
- FIX (one cycle), sign correction:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; negate the remainder if the dividend was negative. Quotient truncates toward zero.
  - Overflow case 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0, with no special flag.
- Divide by zero (op_b == 0 on DIV/DIVU):
  - Latency is the same as a normal divide; no early exit.
  - Result is forced to HI=op_a and LO=0xFFFFFFFF.
  - div_by_zero=1 together with done.
- DONE (one cycle): result is registered, done=1, busy=0. Next cycle returns to IDLE with done=0.
- Latency:
  - start high in cycle c gives busy=1 in cycles c+1..c+WIDTH+1.
  - done=1 in cycle c+WIDTH+2 (c+34 for WIDTH=32).
  - A new start is accepted at the earliest in cycle c+WIDTH+3.
- start while busy or DONE: ignored. Operands are not re-latched and the in-flight op is unaffected.
- op_a and op_b may change freely after the start cycle.
- result changes only at the DONE transition or on reset.

Decomposition:
- Shared package mips_pkg holds:
  - the funct codes FUNCT_MULT/MULTU/DIV/DIVU (shared with the HI/LO control and decoder);
  - the state enum muldiv_state_t {IDLE, RUN, FIX, DONE}.
- One natural sub-module, mips_muldiv_datapath:
  - the accumulator/shift registers and the add/subtract step;
  - the FSM and counter stay in mips_muldiv_unit.

Test Plan:
1. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at c+34, result=0xFFFFFFFE_00000001, busy high exactly 33 cycles.
2. MULT 0xFFFFFFFD (-3) x 5 -> result=0xFFFFFFFF_FFFFFFF1. MULT 0x80000000 x 0x80000000 -> 0x40000000_00000000.
3. DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
4. DIVU 100/0 -> done at c+34, div_by_zero=1 for one cycle, HI=100, LO=0xFFFFFFFF.
5. Handshake and funct filtering:
   - MULTU 3x4, then start pulses with different operands at c+5 and c+20 -> a single done with result=12.
   - start with funct=0x10 -> no busy, no done.
6. reset at c+10 mid-DIV -> next cycle busy=0 and result=0, no done. A fresh MULTU 6x7 afterwards -> result=42.
